db_key_extract: RTL and testbench

- Upstream neighbour of the DB lookup stage. Parses a 64-bit ingress stream from the MAC and extracts the 96-bit flow key: src IP, dst IP, dst UDP port and 16 reserved bits.
- Presents the key with an op flag to the DB controller through a valid/ready handshake.
- Only IPv4 (IHL=5) UDP frames produce a key. All other frames are consumed silently.

---
 rtl/db_pkg.sv | 52 +++++
 rtl/db_keyx_stats.sv | 47 ++++
 rtl/db_key_extract.sv | 176 +++++++++++++++++
 tb/tb_db_key_extract.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/db_pkg.sv
// ---------------------------------------------------------------------------
// db_pkg
// Constants, codes and types shared by the DB pipeline blocks: the key
// extractor in front of the DB lookup stage and the DB controller.
//   - key/value widths
//   - protocol constants used when parsing the ingress frame
//   - op codes carried with a key, status codes reported by the DB
//   - state encoding of the key extractor parser
//   - beat_byte(): byte lane helper for the 64-bit ingress stream
// ---------------------------------------------------------------------------
package db_pkg;

    localparam int KEY_LEN  = 96;
    localparam int VAL_LEN  = 32;
    localparam int FLAG_LEN = 4;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL5 = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;

    // Op codes presented with a key to the DB controller.
    localparam logic [FLAG_LEN-1:0] OP_LOOKUP = 4'h1;
    localparam logic [FLAG_LEN-1:0] OP_INSERT = 4'h2;
    localparam logic [FLAG_LEN-1:0] OP_DELETE = 4'h3;

    // Status codes reported by the DB for a flow.
    typedef enum logic [2:0] {
        ST_NONE    = 3'd0,
        SUSPECTION = 3'd1,
        ARREST     = 3'd2,
        FILTERED   = 3'd3,
        EXPIRED    = 3'd4
    } db_status_t;

    // Parser states: S_Bn expects beat n of the frame, S_SKIP drains the
    // rest of a frame up to and including its tlast beat.
    typedef enum logic [2:0] {
        S_B0   = 3'd0,
        S_B1   = 3'd1,
        S_B2   = 3'd2,
        S_B3   = 3'd3,
        S_B4   = 3'd4,
        S_SKIP = 3'd5
    } keyx_state_t;

    // Byte lane idx of a beat; lane 0 is the first byte on the wire.
    function automatic logic [7:0] beat_byte(input logic [63:0] beat,
                                             input int unsigned idx);
        return beat[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/db_keyx_stats.sv
// ---------------------------------------------------------------------------
// db_keyx_stats
// Saturating statistics counter bank of the key extractor. Each counter
// steps by one on its increment strobe and sticks at all-ones.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (counters -> 0)
//   inc_keys        a key was loaded into the output slot
//   inc_ovf         a key was discarded because the slot was busy
//   inc_nokey       a frame finished parsing without producing a key
//   keys, drop_ovf, drop_nokey   counter values
// ---------------------------------------------------------------------------
module db_keyx_stats
    import db_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_keys,
    input  logic                 inc_ovf,
    input  logic                 inc_nokey,
    output logic [CNT_WIDTH-1:0] keys,
    output logic [CNT_WIDTH-1:0] drop_ovf,
    output logic [CNT_WIDTH-1:0] drop_nokey
);

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keys       <= '0;
            drop_ovf   <= '0;
            drop_nokey <= '0;
        end else begin
            if (inc_keys && (keys != '1)) begin
                keys <= keys + ONE;
            end
            if (inc_ovf && (drop_ovf != '1)) begin
                drop_ovf <= drop_ovf + ONE;
            end
            if (inc_nokey && (drop_nokey != '1)) begin
                drop_nokey <= drop_nokey + ONE;
            end
        end
    end

endmodule

// File: rtl/db_key_extract.sv
// ---------------------------------------------------------------------------
// db_key_extract
// Parses the 64-bit ingress stream from the MAC and extracts the 96-bit
// flow key {src_ip, dst_ip, dst_port, 16'h0} of IPv4 (IHL=5) UDP frames.
// Every other frame is consumed silently. Keys are offered to the DB
// controller through a single-entry output slot.
//
// Handshake: key_out/key_flag are valid while key_valid is high and hold
// steady until key_ready is seen high on a clock edge (transfer). A new key
// arriving while the slot is full and not transferring is dropped.
//
// Optional build macro DB_KEYX_STATS_EN: when defined, stat_* are
// saturating counters (db_keyx_stats); otherwise stat_* are tied to 0.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   s_tdata/tkeep      ingress beat, byte 0 of the beat in [7:0]
//   s_tvalid, s_tlast  beat valid (always accepted), last beat of frame
//   key_out, key_flag  extracted key and op code (OP_LOOKUP)
//   key_valid          key available; key_ready: DB stage accepts it
//   stat_keys          keys loaded into the slot
//   stat_drop_ovf      keys lost because the slot was busy
//   stat_drop_nokey    frames that produced no key
// ---------------------------------------------------------------------------
module db_key_extract
    import db_pkg::*;
#(
    // Fixed layout: only 96 is legal.
    parameter int                   KEY_SIZE  = 96,
    parameter int                   FLAG_SIZE = 4,
    parameter logic [FLAG_SIZE-1:0] OP_LOOKUP = db_pkg::OP_LOOKUP,
    parameter int                   CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [63:0]          s_tdata,
    input  logic [7:0]           s_tkeep,
    input  logic                 s_tvalid,
    input  logic                 s_tlast,
    output logic [KEY_SIZE-1:0]  key_out,
    output logic [FLAG_SIZE-1:0] key_flag,
    output logic                 key_valid,
    input  logic                 key_ready,
    output logic [CNT_WIDTH-1:0] stat_keys,
    output logic [CNT_WIDTH-1:0] stat_drop_ovf,
    output logic [CNT_WIDTH-1:0] stat_drop_nokey
);

    keyx_state_t        state;
    keyx_state_t        state_next;
    keyx_state_t        fail_state;

    logic [31:0]        src_ip;
    logic [15:0]        dst_ip_hi;
    logic               eth_ok;
    logic               proto_ok;
    logic               b3_ok;
    logic               b4_ok;
    logic               load;
    logic               load_accept;
    logic [KEY_LEN-1:0] key_new;

    // Per-beat checks; each covers the data and the keep bits of the bytes
    // that beat contributes.
    assign eth_ok   = (&s_tkeep[6:4])
                   && ({beat_byte(s_tdata, 4), beat_byte(s_tdata, 5)} == ETH_TYPE_IPV4)
                   && (beat_byte(s_tdata, 6) == IPV4_VER_IHL5);
    assign proto_ok = s_tkeep[7] && (beat_byte(s_tdata, 7) == IP_PROTO_UDP);
    assign b3_ok    = &s_tkeep[7:2];
    assign b4_ok    = &s_tkeep[5:0];

    // A rejected frame either ends here or is drained in S_SKIP.
    assign fail_state = s_tlast ? S_B0 : S_SKIP;

    // -----------------------------------------------------------------------
    // Parser FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_B0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        if (s_tvalid) begin
            case (state)
                S_B0:    state_next = ((s_tkeep == 8'hFF) && !s_tlast) ? S_B1 : fail_state;
                S_B1:    state_next = (eth_ok && !s_tlast)   ? S_B2 : fail_state;
                S_B2:    state_next = (proto_ok && !s_tlast) ? S_B3 : fail_state;
                S_B3:    state_next = (b3_ok && !s_tlast)    ? S_B4 : fail_state;
                S_B4: begin
                    load       = b4_ok;
                    state_next = fail_state;
                end
                S_SKIP:  state_next = s_tlast ? S_B0 : S_SKIP;
                default: state_next = S_B0;
            endcase
        end
    end

    // Beat 3 carries src IP (bytes 26-29) and the upper half of dst IP
    // (bytes 30-31); the rest of the key comes straight from beat 4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_ip    <= '0;
            dst_ip_hi <= '0;
        end else if (s_tvalid && (state == S_B3)) begin
            src_ip    <= {beat_byte(s_tdata, 2), beat_byte(s_tdata, 3),
                          beat_byte(s_tdata, 4), beat_byte(s_tdata, 5)};
            dst_ip_hi <= {beat_byte(s_tdata, 6), beat_byte(s_tdata, 7)};
        end
    end

    assign key_new = {src_ip, dst_ip_hi,
                      beat_byte(s_tdata, 0), beat_byte(s_tdata, 1),
                      beat_byte(s_tdata, 4), beat_byte(s_tdata, 5),
                      16'h0000};

    // -----------------------------------------------------------------------
    // Output slot. A load is taken when the slot is empty or is being
    // emptied in the same cycle, so back-to-back keys keep key_valid high.
    // -----------------------------------------------------------------------
    assign load_accept = load && (!key_valid || key_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_out   <= '0;
            key_flag  <= '0;
        end else if (load_accept) begin
            key_valid <= 1'b1;
            key_out   <= key_new;
            key_flag  <= OP_LOOKUP;
        end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Statistics
    // -----------------------------------------------------------------------
`ifdef DB_KEYX_STATS_EN
    logic load_drop;
    logic frame_nokey;

    assign load_drop = load && key_valid && !key_ready;

    // A frame is rejected on the beat where a parsing state leaves the
    // S_B0..S_B4 chain without loading; afterwards it is drained in S_SKIP,
    // so this fires once per rejected frame.
    assign frame_nokey = s_tvalid && (state != S_SKIP) && !load
                      && ((state_next == S_SKIP) || (state_next == S_B0));

    db_keyx_stats #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stats (
        .clk        (clk),
        .rst        (rst),
        .inc_keys   (load_accept),
        .inc_ovf    (load_drop),
        .inc_nokey  (frame_nokey),
        .keys       (stat_keys),
        .drop_ovf   (stat_drop_ovf),
        .drop_nokey (stat_drop_nokey)
    );
`else
    assign stat_keys       = '0;
    assign stat_drop_ovf   = '0;
    assign stat_drop_nokey = '0;
`endif

endmodule

// File: tb/tb_db_key_extract.sv
module tb_db_key_extract;

`ifdef DB_KEYX_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  // ---------------------------------------------------------------- signals
  logic        clk;
  logic        rst;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tlast;
  logic [95:0] key_out;
  logic [3:0]  key_flag;
  logic        key_valid;
  logic        key_ready;
  logic [31:0] stat_keys;
  logic [31:0] stat_drop_ovf;
  logic [31:0] stat_drop_nokey;

  db_key_extract dut (
    .clk             (clk),
    .rst             (rst),
    .s_tdata         (s_tdata),
    .s_tkeep         (s_tkeep),
    .s_tvalid        (s_tvalid),
    .s_tlast         (s_tlast),
    .key_out         (key_out),
    .key_flag        (key_flag),
    .key_valid       (key_valid),
    .key_ready       (key_ready),
    .stat_keys       (stat_keys),
    .stat_drop_ovf   (stat_drop_ovf),
    .stat_drop_nokey (stat_drop_nokey)
  );

  // ------------------------------------------------------ clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------ bench state
  int checks = 0;
  int errors = 0;

  logic [7:0]  fb [96];   // frame bytes, wire order
  logic [7:0]  fk [12];   // tkeep per beat
  int          fnb;       // beats in frame

  // driver -> model side channel: "this beat completes a key"
  logic        drv_load;
  logic [95:0] drv_key;
  logic        rand_ready;
  logic        cmp_en;

  // reference model of the output slot and counters
  logic        m_valid;
  logic [95:0] m_key;
  int          m_keys;
  int          m_ovf;
  int          m_xfers;
  int          m_nokey;     // frame-level tally, owned by the driver
  int          dut_xfers;
  logic [95:0] seen_key;
  logic [3:0]  seen_flag;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------- frame model
  function automatic bit byte_kept(input int i);
    logic [7:0] k;
    k = fk[i / 8];
    return k[i % 8];
  endfunction

  // A frame yields a key iff it has at least 5 beats, all of beat 0 and every
  // byte the key or the header checks rely on is present, and the header
  // identifies IPv4 IHL=5 UDP.
  function automatic bit frame_ok();
    if (fnb < 5) return 1'b0;
    for (int i = 0; i < 8; i++) if (!byte_kept(i)) return 1'b0;
    for (int i = 12; i <= 14; i++) if (!byte_kept(i)) return 1'b0;
    if (!byte_kept(23)) return 1'b0;
    for (int i = 26; i <= 37; i++) if (!byte_kept(i)) return 1'b0;
    if (fb[12] != 8'h08 || fb[13] != 8'h00) return 1'b0;
    if (fb[14] != 8'h45) return 1'b0;
    if (fb[23] != 8'h11) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [95:0] frame_key();
    return {fb[26], fb[27], fb[28], fb[29], fb[30], fb[31], fb[32], fb[33],
            fb[36], fb[37], 16'h0000};
  endfunction

  task automatic build(input logic [31:0] src, input logic [31:0] dst,
                       input logic [15:0] dport, input logic [15:0] etype,
                       input logic [7:0] verihl, input logic [7:0] proto,
                       input int nb);
    for (int i = 0; i < 96; i++) fb[i] = 8'($urandom);
    for (int b = 0; b < 12; b++) fk[b] = 8'hFF;
    fb[12] = etype[15:8];  fb[13] = etype[7:0];
    fb[14] = verihl;
    fb[23] = proto;
    fb[26] = src[31:24]; fb[27] = src[23:16]; fb[28] = src[15:8]; fb[29] = src[7:0];
    fb[30] = dst[31:24]; fb[31] = dst[23:16]; fb[32] = dst[15:8]; fb[33] = dst[7:0];
    fb[36] = dport[15:8]; fb[37] = dport[7:0];
    fnb = nb;
  endtask

  // ------------------------------------------------------------ driver tasks
  task automatic step_ready();
    if (rand_ready) key_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      drv_load = 1'b0;
      step_ready();
    end
  endtask

  // rst_beat >= 0: assert reset while that beat is on the bus and abandon
  // the frame. ready_beat >= 0: raise key_ready together with that beat.
  task automatic send_frame(input bit gaps, input int rst_beat, input int ready_beat);
    bit          ok;
    logic [95:0] k;
    logic [63:0] d;
    ok = frame_ok();
    k  = frame_key();
    if (!ok) m_nokey++;
    for (int n = 0; n < fnb; n++) begin
      if (gaps) idle($urandom_range(0, 2));
      @(negedge clk);
      for (int b = 0; b < 8; b++) d[8*b +: 8] = fb[8*n + b];
      s_tdata  = d;
      s_tkeep  = fk[n];
      s_tvalid = 1'b1;
      s_tlast  = (n == fnb - 1);
      drv_load = ok && (n == 4);
      drv_key  = k;
      step_ready();
      if (n == ready_beat) key_ready = 1'b1;
      if (n == rst_beat) begin
        rst = 1'b1;
        m_nokey = 0;
        #1;
        check("rst_key_valid_immediate", key_valid, 1'b0);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        drv_load = 1'b0;
        rst      = 1'b0;
        return;
      end
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_stat_keys"},  stat_keys,       STATS_ON ? 32'(m_keys)  : 32'd0);
    check({tag, "_stat_ovf"},   stat_drop_ovf,   STATS_ON ? 32'(m_ovf)   : 32'd0);
    check({tag, "_stat_nokey"}, stat_drop_nokey, STATS_ON ? 32'(m_nokey) : 32'd0);
  endtask

  // ---------------------------------------------------- reference model
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_key   = '0;
      m_keys  = 0;
      m_ovf   = 0;
      m_xfers = 0;
    end else begin
      if (m_valid && key_ready) m_xfers++;
      if (s_tvalid && drv_load) begin
        if (!m_valid || key_ready) begin
          m_valid = 1'b1;
          m_key   = drv_key;
          m_keys++;
        end else begin
          m_ovf++;
        end
      end else if (m_valid && key_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) dut_xfers = 0;
    else if (key_valid && key_ready) dut_xfers++;
  end

  // ------------------------------------------------ per-cycle scoreboard
  logic [95:0] exp_q[$];
  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      check("key_valid", key_valid, m_valid);
      if (m_valid) begin
        check("key_out", key_out, m_key);
        check("key_flag", key_flag, 4'h1);
      end
      if (key_valid) begin
        seen_key  = key_out;
        seen_flag = key_flag;
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  int nk0, ov0, x0, kind;
  logic [31:0] rs, rd;
  logic [15:0] rp;

  initial begin
    rst = 1'b1; s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    key_ready = 1'b0; drv_load = 1'b0; drv_key = '0; rand_ready = 1'b0;
    cmp_en = 1'b0; m_nokey = 0; seen_key = '0; seen_flag = '0;
    m_valid = 1'b0; m_key = '0;

    repeat (2) @(negedge clk);
    check("reset_key_valid", key_valid, 1'b0);
    check("reset_key_out", key_out, 96'h0);
    check("reset_key_flag", key_flag, 4'h0);
    check("reset_stat_keys", stat_keys, 32'h0);
    check("reset_stat_ovf", stat_drop_ovf, 32'h0);
    check("reset_stat_nokey", stat_drop_nokey, 32'h0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // T1: basic UDP, DNS
    key_ready = 1'b1;
    build(32'h0A000001, 32'h0A000002, 16'd53, 16'h0800, 8'h45, 8'h11, 6);
    check("t1_model_key", frame_key(), 96'h0A000001_0A000002_0035_0000);
    send_frame(1'b0, -1, -1);
    idle(3);
    check("t1_key", seen_key, 96'h0A000001_0A000002_0035_0000);
    check("t1_flag", seen_flag, 4'h1);
    check("t1_model_keys", m_keys, 1);
    check("t1_stat_keys", stat_keys, STATS_ON ? 32'd1 : 32'd0);

    // T2: TCP then ARP
    nk0 = int'(stat_drop_nokey); x0 = dut_xfers;
    build(32'h0A000001, 32'h0A000002, 16'd53, 16'h0800, 8'h45, 8'h06, 6);
    send_frame(1'b0, -1, -1);
    idle(1);
    build(32'h0A000001, 32'h0A000002, 16'd53, 16'h0806, 8'h45, 8'h11, 6);
    send_frame(1'b0, -1, -1);
    idle(3);
    check("t2_nokey", int'(stat_drop_nokey) - nk0, STATS_ON ? 2 : 0);
    check("t2_no_transfer", dut_xfers - x0, 0);
    check("t2_model_nokey", m_nokey, 2);

    // T3: IHL=6, then 3-beat frame, then a good frame
    nk0 = int'(stat_drop_nokey);
    build(32'h0A000001, 32'h0A000002, 16'd53, 16'h0800, 8'h46, 8'h11, 6);
    send_frame(1'b0, -1, -1);
    build(32'h0A000001, 32'h0A000002, 16'd53, 16'h0800, 8'h45, 8'h11, 3);
    send_frame(1'b0, -1, -1);
    build(32'hC0A80101, 32'hC0A80102, 16'd80, 16'h0800, 8'h45, 8'h11, 5);
    send_frame(1'b0, -1, -1);
    idle(3);
    check("t3_nokey", int'(stat_drop_nokey) - nk0, STATS_ON ? 2 : 0);
    check("t3_key", seen_key, 96'hC0A80101_C0A80102_0050_0000);

    // T4: slot busy, second key dropped
    key_ready = 1'b0;
    ov0 = int'(stat_drop_ovf); x0 = dut_xfers;
    build(32'h0A000001, 32'h0A000002, 16'd53, 16'h0800, 8'h45, 8'h11, 6);
    send_frame(1'b0, -1, -1);
    build(32'h0A000001, 32'h0A000002, 16'd123, 16'h0800, 8'h45, 8'h11, 6);
    send_frame(1'b0, -1, -1);
    idle(3);
    check("t4_valid_held", key_valid, 1'b1);
    check("t4_key_dport", key_out[31:16], 16'h0035);
    check("t4_ovf", int'(stat_drop_ovf) - ov0, STATS_ON ? 1 : 0);
    key_ready = 1'b1;
    idle(3);
    check("t4_one_transfer", dut_xfers - x0, 1);
    check("t4_valid_cleared", key_valid, 1'b0);

    // T5: transfer and load in the same cycle
    key_ready = 1'b0;
    ov0 = int'(stat_drop_ovf);
    build(32'h0A000001, 32'h0A000002, 16'd1000, 16'h0800, 8'h45, 8'h11, 5);
    send_frame(1'b0, -1, -1);
    idle(2);
    build(32'h0A000003, 32'h0A000004, 16'd2000, 16'h0800, 8'h45, 8'h11, 5);
    send_frame(1'b0, -1, 4);
    idle(3);
    check("t5_ovf", int'(stat_drop_ovf) - ov0, 0);
    check("t5_key", seen_key, 96'h0A000003_0A000004_07D0_0000);

    // T6: gaps inside a frame
    key_ready = 1'b1;
    build(32'h0A000001, 32'h0A000002, 16'd53, 16'h0800, 8'h45, 8'h11, 6);
    send_frame(1'b1, -1, -1);
    idle(3);
    check("t6_key_gaps", seen_key, 96'h0A000001_0A000002_0035_0000);

    // T7: reset during beat 3 with a key pending
    key_ready = 1'b0;
    build(32'h0A000001, 32'h0A000002, 16'd53, 16'h0800, 8'h45, 8'h11, 6);
    send_frame(1'b0, -1, -1);
    idle(2);
    build(32'h0A000001, 32'h0A000002, 16'd99, 16'h0800, 8'h45, 8'h11, 6);
    send_frame(1'b0, 3, -1);
    idle(1);
    check_stats("t7_after_rst");
    key_ready = 1'b1;
    build(32'h0A000001, 32'h0A000002, 16'd7, 16'h0800, 8'h45, 8'h11, 6);
    send_frame(1'b0, -1, -1);
    idle(3);
    check("t7_key", seen_key, 96'h0A000001_0A000002_0007_0000);
    check("t7_stat_keys", stat_keys, STATS_ON ? 32'd1 : 32'd0);

    // Random frames with random ready and gaps
    rand_ready = 1'b1;
    for (int f = 0; f < 150; f++) begin
      rs = $urandom; rd = $urandom; rp = 16'($urandom);
      kind = $urandom_range(0, 9);
      case (kind)
        5: build(rs, rd, rp, 16'h0800, 8'h45, 8'h06, $urandom_range(5, 8));
        6: build(rs, rd, rp, 16'h0806, 8'h45, 8'h11, $urandom_range(5, 8));
        7: build(rs, rd, rp, 16'h0800, 8'h46, 8'h11, $urandom_range(5, 8));
        8: build(rs, rd, rp, 16'h0800, 8'h45, 8'h11, $urandom_range(1, 4));
        9: begin
          build(rs, rd, rp, 16'h0800, 8'h45, 8'h11, $urandom_range(5, 8));
          fk[$urandom_range(0, fnb - 1)][$urandom_range(0, 7)] = 1'b0;
        end
        default: build(rs, rd, rp, 16'h0800, 8'h45, 8'h11, $urandom_range(5, 8));
      endcase
      send_frame(1'($urandom_range(0, 1)), -1, -1);
      idle($urandom_range(0, 2));
    end
    rand_ready = 1'b0;
    key_ready  = 1'b1;
    idle(4);
    check_stats("random_end");
    check("random_transfers", dut_xfers, m_xfers);
    check("random_slot_empty", key_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
